// File: rtl/mbscore_int_arbiter.sv
// Interrupt arbiter: synchronises and edge-detects device interrupt lines into
// a pending register, applies mask and fixed priority, and hands one encoded
// request at a time to the interrupt controller (ack / end-of-interrupt).

// One source lane: three-flop synchroniser, rising-edge detect, pending bit.
module mbscore_int_lane (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pending
);
    logic s1, s2, s3;
    logic rise;

    assign rise = s2 & ~s3;

    // Synchroniser chain and pending bit; a same-cycle edge beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            pending <= 1'b0;
        end else begin
            s1      <= irq;
            s2      <= s1;
            s3      <= s2;
            pending <= (pending & ~clr) | rise;
        end
    end
endmodule

module mbscore_int_arbiter #(
    parameter int NUM_SRC       = 5,
    parameter int INT_SEL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       irq_in,
    input  logic                     mask_we,
    input  logic [NUM_SRC-1:0]       mask_wdata,
    input  logic                     int_en_n,
    input  logic                     int_ack,
    input  logic                     int_eoi,
    output logic [INT_SEL_WIDTH-1:0] int_vec,
    output logic [NUM_SRC-1:0]       pending_q,
    output logic [NUM_SRC-1:0]       mask_q,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                   state, state_nxt;
    logic [INT_SEL_WIDTH-1:0] vec_q, vec_nxt;
    logic [INT_SEL_WIDTH-1:0] pick;
    logic [NUM_SRC-1:0]       eligible;
    logic [NUM_SRC-1:0]       clr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            mbscore_int_lane u_lane (
                .clk     (clk),
                .rst     (rst),
                .irq     (irq_in[gi]),
                .clr     (clr[gi]),
                .pending (pending_q[gi])
            );
        end
    endgenerate

    // Mask register; all sources disabled out of reset.
    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= '1;
        else if (mask_we)
            mask_q <= mask_wdata;
    end

    assign eligible = pending_q & ~mask_q;

    // Fixed priority: scan downward so the lowest eligible index wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i])
                pick = INT_SEL_WIDTH'(i + 1);
    end

    // State register and the latched request code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec_q <= '0;
        end else begin
            state <= state_nxt;
            vec_q <= vec_nxt;
        end
    end

    // Next state: the code is frozen once in REQ, so late arrivals and mask
    // edits cannot change a request the controller may already be decoding.
    always_comb begin
        state_nxt = state;
        vec_nxt   = vec_q;
        case (state)
            IDLE: begin
                if (!int_en_n && (eligible != '0)) begin
                    state_nxt = REQ;
                    vec_nxt   = pick;
                end
            end
            REQ: begin
                if (int_ack)
                    state_nxt = SERVICE;
                else if (int_en_n)
                    state_nxt = IDLE;
            end
            SERVICE: begin
                if (int_eoi)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the vector shows only in REQ; ack clears the selected source.
    always_comb begin
        int_vec = (state == REQ) ? vec_q : '0;
        busy    = (state == SERVICE);
        for (int i = 0; i < NUM_SRC; i++)
            clr[i] = (state == REQ) && int_ack && (vec_q == INT_SEL_WIDTH'(i + 1));
    end
endmodule

// File: tb/tb_mbscore_int_arbiter.sv
// Bench for mbscore_int_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_mbscore_int_arbiter;
    localparam int N = 5;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         int_en_n;
    logic         int_ack;
    logic         int_eoi;
    logic [W-1:0] int_vec;
    logic [N-1:0] pending_q;
    logic [N-1:0] mask_q;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model: 0 = idle, 1 = request shown, 2 = being serviced.
    int           m_mode;
    int           m_vec;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_mask;
    logic [N-1:0] hist[$];

    mbscore_int_arbiter #(.NUM_SRC(N), .INT_SEL_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_en_n   (int_en_n),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
        .int_vec    (int_vec),
        .pending_q  (pending_q),
        .mask_q     (mask_q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at it.
    task automatic model_edge();
        logic [N-1:0] rise, clr, elig, iso;
        if (rst) begin
            m_mode = 0; m_vec = 0; m_pend = '0; m_mask = '1;
            hist = '{5'b0, 5'b0, 5'b0, 5'b0};
            return;
        end
        // A line sampled high two edges ago after being low three edges ago
        // becomes a new pending event now.
        hist.push_front(irq_in);
        void'(hist.pop_back());
        rise = hist[2] & ~hist[3];
        clr  = '0;
        elig = m_pend & ~m_mask;
        case (m_mode)
            0: if (!int_en_n && elig != 0) begin
                iso    = elig & (~elig + 1'b1);
                m_vec  = $clog2(iso) + 1;
                m_mode = 1;
            end
            1: if (int_ack) begin
                clr[m_vec-1] = 1'b1;
                m_mode       = 2;
            end else if (int_en_n) begin
                m_mode = 0;
            end
            default: if (int_eoi) m_mode = 0;
        endcase
        m_pend = (m_pend & ~clr) | rise;
        if (mask_we) m_mask = mask_wdata;
    endtask

    // One cycle: edge, model update, compare all outputs, drop one-shot pulses.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("int_vec",   32'(int_vec),   (m_mode == 1) ? m_vec : 0);
        check("pending_q", 32'(pending_q), 32'(m_pend));
        check("mask_q",    32'(mask_q),    32'(m_mask));
        check("busy",      32'(busy),      (m_mode == 2) ? 1 : 0);
        int_ack = 1'b0;
        int_eoi = 1'b0;
        mask_we = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
    endtask

    task automatic do_eoi();
        int_eoi = 1'b1;
        tick();
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        int_en_n = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
        m_mode = 0; m_vec = 0; m_pend = '0; m_mask = '1;
        hist = '{5'b0, 5'b0, 5'b0, 5'b0};

        // Reset state
        ticks(2);
        check("rst_mask", 32'(mask_q), 32'h1f);
        check("rst_vec",  32'(int_vec), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        write_mask(5'b00000);

        // UART pulse: pending after k+2, vector after k+3, held until ack
        irq_in = 5'b00100;
        tick();                                   // edge k
        tick();                                   // edge k+1
        check("uart_pend_k1", 32'(pending_q), 0);
        tick();                                   // edge k+2
        check("uart_pend_k2", 32'(pending_q), 32'b00100);
        tick();                                   // edge k+3
        check("uart_vec", 32'(int_vec), 3);
        irq_in = '0;
        ticks(3);
        check("uart_hold", 32'(int_vec), 3);
        do_ack();
        check("uart_ack_vec",  32'(int_vec), 0);
        check("uart_ack_pend", 32'(pending_q), 0);
        check("uart_ack_busy", 32'(busy), 1);
        do_eoi();
        check("uart_eoi_busy", 32'(busy), 0);

        // Mouse and ethernet together: mouse first, ethernet right after eoi
        irq_in = 5'b10010;
        tick();
        irq_in = '0;
        ticks(3);
        check("mouse_vec", 32'(int_vec), 2);
        do_ack();
        do_eoi();
        tick();
        check("eth_vec", 32'(int_vec), 5);

        // Keyboard arriving while ethernet is held does not preempt it
        irq_in = 5'b00001;
        tick();
        irq_in = '0;
        ticks(3);
        check("nopreempt_pend", 32'(pending_q[0]), 1);
        check("nopreempt_vec",  32'(int_vec), 5);
        do_ack();
        do_eoi();
        tick();
        check("kbd_vec", 32'(int_vec), 1);
        do_ack();
        do_eoi();

        // Masked keyboard stays pending; unmask makes it eligible next cycle
        write_mask(5'b00001);
        irq_in = 5'b00001;
        tick();
        irq_in = '0;
        ticks(4);
        check("masked_pend", 32'(pending_q), 32'b00001);
        check("masked_vec",  32'(int_vec), 0);
        write_mask(5'b00000);
        check("unmask_same", 32'(int_vec), 0);
        tick();
        check("unmask_vec", 32'(int_vec), 1);
        do_ack();
        do_eoi();

        // Global disable, enable, withdraw before ack
        int_en_n = 1'b1;
        irq_in = 5'b01000;
        tick();
        irq_in = '0;
        ticks(4);
        check("dis_pend", 32'(pending_q), 32'b01000);
        check("dis_vec",  32'(int_vec), 0);
        int_en_n = 1'b0;
        tick();
        check("en_vec", 32'(int_vec), 4);
        int_en_n = 1'b1;
        tick();
        check("wd_vec",  32'(int_vec), 0);
        check("wd_pend", 32'(pending_q), 32'b01000);
        int_en_n = 1'b0;
        tick();
        check("reen_vec", 32'(int_vec), 4);
        do_ack();
        do_eoi();

        // New mouse edge on the ack edge of a mouse request: set wins
        irq_in = 5'b00010; tick();                // e0
        irq_in = '0;       ticks(2);              // e1, e2
        irq_in = 5'b00010; tick();                // e3
        check("m2_vec", 32'(int_vec), 2);
        irq_in = '0;       tick();                // e4
        do_ack();                                 // e5: rise from e3 lands here
        check("setwins_pend", 32'(pending_q[1]), 1);
        check("setwins_busy", 32'(busy), 1);

        // Reset during service
        rst = 1'b1;
        tick();
        check("midrst_vec",  32'(int_vec), 0);
        check("midrst_pend", 32'(pending_q), 0);
        check("midrst_mask", 32'(mask_q), 32'h1f);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        check("postrst_busy", 32'(busy), 0);

        // Random traffic against the model
        write_mask(5'b00000);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(99, 0) < 12) irq_in[b] = ~irq_in[b];
            int_en_n = ($urandom_range(99, 0) < 10);
            int_ack  = ($urandom_range(99, 0) < 30);
            int_eoi  = ($urandom_range(99, 0) < 20);
            if ($urandom_range(99, 0) < 3) begin
                mask_we    = 1'b1;
                mask_wdata = N'($urandom_range(31, 0)) & N'($urandom_range(31, 0));
            end
            rst = ($urandom_range(999, 0) < 3);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
